ring_rr_arbiter: RTL

- Round-robin arbiter that shares one resource among N requesters.
- Priority is held in a one-hot ring token that rotates like the ring counter datapath, so the token is always `$onehot`.
- The arbiter issues at most one grant at a time. A grant is held until the owner releases it or a hold-limit timeout fires.
- Sits in front of the shared resource; the bench checks the one-hot invariants with assertions on the interface.

---
 rtl/ring_rr_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/ring_rr_arbiter.sv
// rtl/ring_rr_arbiter.sv - round-robin arbiter with a one-hot rotating priority token
module ring_rr_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] done,
    output logic [N-1:0] gnt,
    output logic [N-1:0] token,
    output logic         busy,
    output logic         timeout,
    output logic [7:0]   hold_cnt
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    localparam logic [7:0]   HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [N-1:0] TOKEN_RST = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q;
    logic [N-1:0] gnt_q;
    logic [N-1:0] token_q;
    logic [7:0]   hold_q;
    logic         timeout_q;

    int           tok_pos;
    int           scan_pos;
    logic [N-1:0] win_oh;
    logic         win_found;

    logic         owner_done;
    logic         owner_dropped;
    logic         at_limit;
    logic         release_c;
    logic         forced_c;

    // Circular scan starting at the token bit: first requester found wins.
    always_comb begin
        tok_pos   = 0;
        scan_pos  = 0;
        win_oh    = '0;
        win_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (token_q[i]) begin
                tok_pos = i;
            end
        end
        for (int k = 0; k < N; k++) begin
            scan_pos = (tok_pos + k) % N;
            if (!win_found && req[scan_pos]) begin
                win_found        = 1'b1;
                win_oh[scan_pos] = 1'b1;
            end
        end
    end

    // Only the owner's done/req bits matter while granted.
    always_comb begin
        owner_done    = |(done & gnt_q);
        owner_dropped = ~|(req & gnt_q);
        at_limit      = (hold_q == HOLD_MAX);
        release_c     = owner_done | owner_dropped | at_limit;
        forced_c      = at_limit & ~owner_done & ~owner_dropped;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            token_q   <= TOKEN_RST;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        gnt_q   <= win_oh;
                        hold_q  <= 8'd1;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (release_c) begin
                        gnt_q     <= '0;
                        token_q   <= {gnt_q[N-2:0], gnt_q[N-1]};
                        hold_q    <= '0;
                        timeout_q <= forced_c;
                        state_q   <= S_IDLE;
                    end else if (hold_q != HOLD_MAX) begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign token    = token_q;
    assign busy     = (state_q == S_GRANT);
    assign timeout  = timeout_q;
    assign hold_cnt = hold_q;

endmodule
